// File: rtl/nav_sequencer.sv
// nav_sequencer: top-level rover navigation sequencer.
// Drives ultrasound fixes, a fixed probe move, orientation/path helper
// requests, the IR-transmitted move command and a closed-loop equality
// check. Retries up to MAX_ITER passes before flagging an error.
module nav_sequencer #(
  parameter int unsigned SETTLE_CYCLES     = 27000000,
  parameter int unsigned IR_HOLD_CYCLES    = 5000000,
  parameter int unsigned UNIT_CYCLES       = 27000000,
  parameter logic [11:0] ORIENT_MOVE       = 12'h00A,
  parameter int unsigned MAX_ITER          = 4,
  parameter int unsigned US_TIMEOUT_CYCLES = 54000000,
  parameter int unsigned ITER_W            = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run_program,
  input  logic              abort,
  input  logic [11:0]       target_location,
  input  logic [11:0]       rover_location,
  output logic              run_ultrasound,
  input  logic              ultrasound_done,
  output logic              clear_us,
  output logic              orient_enable,
  output logic [11:0]       orient_loc_a,
  output logic [11:0]       orient_loc_b,
  input  logic              orient_done,
  input  logic [4:0]        orient_result,
  output logic              path_enable,
  output logic [4:0]        needed_orientation,
  input  logic              path_done,
  input  logic [11:0]       path_command,
  output logic              equal_enable,
  input  logic              equal_done,
  input  logic              equal_result,
  output logic [4:0]        orientation,
  output logic [11:0]       move_command,
  output logic              transmit_ir,
  output logic              busy,
  output logic              reached_target,
  output logic              error,
  output logic [1:0]        error_code,
  output logic [ITER_W-1:0] iteration,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'h0,
    ST_US1     = 4'h1,
    ST_SETTLE1 = 4'h2,
    ST_IRTX1   = 4'h3,
    ST_MOVE1   = 4'h4,
    ST_US2     = 4'h5,
    ST_SETTLE2 = 4'h6,
    ST_ORIENT  = 4'h7,
    ST_PORIENT = 4'h8,
    ST_PCALC   = 4'h9,
    ST_IRTX2   = 4'hA,
    ST_MOVE2   = 4'hB,
    ST_US3     = 4'hC,
    ST_SETTLE3 = 4'hD,
    ST_CHECK   = 4'hE,
    ST_ERROR   = 4'hF
  } state_t;

  // Last-cycle values of each timed state; all timers count up from zero.
  localparam logic [31:0] SETTLE_LAST     = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] IR_LAST         = 32'(IR_HOLD_CYCLES - 1);
  localparam logic [31:0] UNIT_LAST       = 32'(UNIT_CYCLES - 1);
  localparam logic [31:0] US_TIMEOUT_LAST = 32'(US_TIMEOUT_CYCLES - 1);
  localparam logic [ITER_W-1:0] MAX_ITER_W = ITER_W'(MAX_ITER);
  // A zero-length probe move still takes one unit so the rover actually moves.
  localparam logic [8:0] ORIENT_UNITS =
    (ORIENT_MOVE[7:0] == 8'd0) ? 9'd1 : {1'b0, ORIENT_MOVE[7:0]};

  // Move length in units: r + theta + 1, widened so 255 + 15 + 1 cannot wrap.
  function automatic logic [8:0] path_units(input logic [11:0] cmd);
    return {1'b0, cmd[7:0]} + {5'b00000, cmd[11:8]} + 9'd1;
  endfunction

  state_t            state_r;
  logic [31:0]       timer_r;
  logic [8:0]        unit_count_r;
  logic [8:0]        move_units_r;
  logic [ITER_W-1:0] iter_next_s;

  assign iter_next_s = iteration + ITER_W'(1);
  assign state       = state_r;
  assign busy        = (state_r != ST_IDLE);

  // Sequencer FSM with all outputs registered; abort overrides every state action.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r            <= ST_IDLE;
      timer_r            <= 32'd0;
      unit_count_r       <= 9'd0;
      move_units_r       <= 9'd0;
      run_ultrasound     <= 1'b0;
      clear_us           <= 1'b0;
      orient_enable      <= 1'b0;
      orient_loc_a       <= 12'h000;
      orient_loc_b       <= 12'h000;
      path_enable        <= 1'b0;
      needed_orientation <= 5'd0;
      equal_enable       <= 1'b0;
      orientation        <= 5'd0;
      move_command       <= 12'h000;
      transmit_ir        <= 1'b0;
      reached_target     <= 1'b0;
      error              <= 1'b0;
      error_code         <= 2'd0;
      iteration          <= '0;
    end else begin
      // Start pulses are single-cycle unless a transition below re-asserts them.
      run_ultrasound <= 1'b0;
      orient_enable  <= 1'b0;
      path_enable    <= 1'b0;
      equal_enable   <= 1'b0;

      if (abort && (state_r != ST_IDLE) && (state_r != ST_ERROR)) begin
        state_r     <= ST_ERROR;
        timer_r     <= 32'd0;
        error       <= 1'b1;
        error_code  <= 2'd3;
        transmit_ir <= 1'b0;
        clear_us    <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE, ST_ERROR: begin
            if (run_program) begin
              orient_loc_a       <= 12'h000;
              orient_loc_b       <= 12'h000;
              needed_orientation <= 5'd0;
              orientation        <= 5'd0;
              move_command       <= 12'h000;
              reached_target     <= 1'b0;
              error              <= 1'b0;
              error_code         <= 2'd0;
              iteration          <= '0;
              run_ultrasound     <= 1'b1;
              timer_r            <= 32'd0;
              state_r            <= ST_US1;
            end else begin
              transmit_ir <= 1'b0;
              clear_us    <= 1'b0;
            end
          end

          ST_US1, ST_US2, ST_US3: begin
            if (ultrasound_done) begin
              timer_r <= 32'd0;
              case (state_r)
                ST_US1:  state_r <= ST_SETTLE1;
                ST_US2:  state_r <= ST_SETTLE2;
                ST_US3:  state_r <= ST_SETTLE3;
                default: state_r <= ST_ERROR;
              endcase
            end else if (timer_r == US_TIMEOUT_LAST) begin
              timer_r    <= 32'd0;
              error      <= 1'b1;
              error_code <= 2'd1;
              state_r    <= ST_ERROR;
            end else begin
              timer_r <= timer_r + 32'd1;
            end
          end

          ST_SETTLE1: begin
            if (timer_r == SETTLE_LAST) begin
              orient_loc_a <= rover_location;
              move_command <= ORIENT_MOVE;
              move_units_r <= ORIENT_UNITS;
              transmit_ir  <= 1'b1;
              clear_us     <= 1'b1;
              timer_r      <= 32'd0;
              state_r      <= ST_IRTX1;
            end else begin
              timer_r <= timer_r + 32'd1;
            end
          end

          ST_SETTLE2: begin
            if (timer_r == SETTLE_LAST) begin
              orient_loc_b  <= rover_location;
              orient_enable <= 1'b1;
              timer_r       <= 32'd0;
              state_r       <= ST_ORIENT;
            end else begin
              timer_r <= timer_r + 32'd1;
            end
          end

          ST_SETTLE3: begin
            if (timer_r == SETTLE_LAST) begin
              equal_enable <= 1'b1;
              timer_r      <= 32'd0;
              state_r      <= ST_CHECK;
            end else begin
              timer_r <= timer_r + 32'd1;
            end
          end

          ST_IRTX1, ST_IRTX2: begin
            if (timer_r == IR_LAST) begin
              transmit_ir  <= 1'b0;
              clear_us     <= 1'b0;
              timer_r      <= 32'd0;
              unit_count_r <= 9'd1;
              state_r      <= (state_r == ST_IRTX1) ? ST_MOVE1 : ST_MOVE2;
            end else begin
              timer_r <= timer_r + 32'd1;
            end
          end

          ST_MOVE1, ST_MOVE2: begin
            if (timer_r == UNIT_LAST) begin
              timer_r <= 32'd0;
              if (unit_count_r == move_units_r) begin
                run_ultrasound <= 1'b1;
                state_r        <= (state_r == ST_MOVE1) ? ST_US2 : ST_US3;
              end else begin
                unit_count_r <= unit_count_r + 9'd1;
              end
            end else begin
              timer_r <= timer_r + 32'd1;
            end
          end

          ST_ORIENT: begin
            if (orient_done) begin
              orientation   <= orient_result;
              orient_loc_a  <= rover_location;
              orient_loc_b  <= target_location;
              orient_enable <= 1'b1;
              state_r       <= ST_PORIENT;
            end else begin
              state_r <= ST_ORIENT;
            end
          end

          ST_PORIENT: begin
            if (orient_done) begin
              needed_orientation <= orient_result;
              path_enable        <= 1'b1;
              state_r            <= ST_PCALC;
            end else begin
              state_r <= ST_PORIENT;
            end
          end

          ST_PCALC: begin
            if (path_done) begin
              move_command <= path_command;
              move_units_r <= path_units(path_command);
              transmit_ir  <= 1'b1;
              clear_us     <= 1'b1;
              timer_r      <= 32'd0;
              state_r      <= ST_IRTX2;
            end else begin
              state_r <= ST_PCALC;
            end
          end

          ST_CHECK: begin
            if (equal_done) begin
              iteration <= iter_next_s;
              timer_r   <= 32'd0;
              if (equal_result) begin
                reached_target <= 1'b1;
                state_r        <= ST_IDLE;
              end else if (iter_next_s == MAX_ITER_W) begin
                error      <= 1'b1;
                error_code <= 2'd2;
                state_r    <= ST_ERROR;
              end else begin
                reached_target <= 1'b0;
                run_ultrasound <= 1'b1;
                state_r        <= ST_US1;
              end
            end else begin
              state_r <= ST_CHECK;
            end
          end

          default: begin
            transmit_ir <= 1'b0;
            clear_us    <= 1'b0;
            state_r     <= ST_ERROR;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nav_sequencer.sv
// tb_nav_sequencer: directed scoreboard bench for nav_sequencer.
// Each run pushes its hand-computed end-of-run record; a negedge monitor
// accumulates activity (IR runs, pulses, dwell lengths) and compares the
// record whenever the DUT leaves the busy states.
module tb_nav_sequencer;
  localparam int SETTLE = 4;
  localparam int IRH    = 3;
  localparam int UNIT   = 5;
  localparam int MAXI   = 2;
  localparam int UST    = 20;

  logic        clock = 1'b0;
  logic        reset, run_program, abort;
  logic [11:0] target_location, rover_location;
  logic        run_ultrasound, ultrasound_done, clear_us;
  logic        orient_enable, orient_done;
  logic [11:0] orient_loc_a, orient_loc_b;
  logic [4:0]  orient_result, needed_orientation, orientation;
  logic        path_enable, path_done;
  logic [11:0] path_command, move_command;
  logic        equal_enable, equal_done, equal_result;
  logic        transmit_ir, busy, reached_target, error;
  logic [1:0]  error_code;
  logic [2:0]  iteration;
  logic [3:0]  state;

  always #5 clock = ~clock;

  nav_sequencer #(
    .SETTLE_CYCLES(SETTLE), .IR_HOLD_CYCLES(IRH), .UNIT_CYCLES(UNIT),
    .ORIENT_MOVE(12'h00A), .MAX_ITER(MAXI), .US_TIMEOUT_CYCLES(UST), .ITER_W(3)
  ) dut (
    .clock(clock), .reset(reset), .run_program(run_program), .abort(abort),
    .target_location(target_location), .rover_location(rover_location),
    .run_ultrasound(run_ultrasound), .ultrasound_done(ultrasound_done),
    .clear_us(clear_us), .orient_enable(orient_enable),
    .orient_loc_a(orient_loc_a), .orient_loc_b(orient_loc_b),
    .orient_done(orient_done), .orient_result(orient_result),
    .path_enable(path_enable), .needed_orientation(needed_orientation),
    .path_done(path_done), .path_command(path_command),
    .equal_enable(equal_enable), .equal_done(equal_done),
    .equal_result(equal_result), .orientation(orientation),
    .move_command(move_command), .transmit_ir(transmit_ir), .busy(busy),
    .reached_target(reached_target), .error(error), .error_code(error_code),
    .iteration(iteration), .state(state)
  );

  typedef struct {
    int st, reached, err, code, iter, mcmd, tx, clr, ori, need, loca, locb;
    int irr, irc, m2, us2, usp, pe, pas;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input int st, reached, err, code, iter, mcmd, tx, clr,
                              ori, need, loca, locb, irr, irc, m2, us2, usp, pe, pas);
    exp_t e;
    e.st = st; e.reached = reached; e.err = err; e.code = code; e.iter = iter;
    e.mcmd = mcmd; e.tx = tx; e.clr = clr; e.ori = ori; e.need = need;
    e.loca = loca; e.locb = locb; e.irr = irr; e.irc = irc; e.m2 = m2;
    e.us2 = us2; e.usp = usp; e.pe = pe; e.pas = pas;
    return e;
  endfunction

  function automatic bit idle_like(input int s);
    return (s == 0) || (s == 15);
  endfunction

  // Monitor: accumulate run activity and check the scoreboard at each run end.
  int prev_st = 0, tx_prev = 0, abort_prev = 0;
  int irr = 0, irc = 0, m2 = 0, us2 = 0, usp = 0, pe = 0, pas = 0;
  exp_t me;
  always @(negedge clock) begin
    if (idle_like(prev_st) && !idle_like(int'(state))) begin
      irr = 0; irc = 0; m2 = 0; us2 = 0; usp = 0; pe = 0; pas = 0;
    end
    if (abort_prev != 0) pas = int'(state);
    if (transmit_ir) begin
      irc++;
      if (tx_prev == 0) irr++;
    end
    if (state == 4'hB) begin
      if (prev_st != 11) m2 = 0;
      m2++;
    end
    if (state == 4'h5) begin
      if (prev_st != 5) us2 = 0;
      us2++;
    end
    if (run_ultrasound) usp++;
    if (path_enable) pe++;
    if (!idle_like(prev_st) && idle_like(int'(state))) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected_end: got state %0h expected no run end", state);
      end else begin
        me = sb.pop_front();
        cmp("state", state, me.st);            cmp("reached_target", reached_target, me.reached);
        cmp("error", error, me.err);           cmp("error_code", error_code, me.code);
        cmp("iteration", iteration, me.iter);  cmp("move_command", move_command, me.mcmd);
        cmp("transmit_ir", transmit_ir, me.tx); cmp("clear_us", clear_us, me.clr);
        cmp("orientation", orientation, me.ori); cmp("needed_orientation", needed_orientation, me.need);
        cmp("orient_loc_a", orient_loc_a, me.loca); cmp("orient_loc_b", orient_loc_b, me.locb);
        cmp("ir_runs", irr, me.irr);           cmp("ir_cycles", irc, me.irc);
        cmp("move2_len", m2, me.m2);           cmp("us2_len", us2, me.us2);
        cmp("us_pulses", usp, me.usp);         cmp("path_en_pulses", pe, me.pe);
        cmp("post_abort_state", pas, me.pas);
      end
    end
    prev_st = int'(state);
    tx_prev = int'(transmit_ir);
    abort_prev = int'(abort);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while ((int'(state) != s) && (n < budget)) begin
      step();
      n++;
    end
    if (int'(state) != s) begin
      checks++; errors++;
      $display("FAIL wait_state: got state %0h expected %0h within %0d cycles", state, s, budget);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  endtask

  task automatic start_run();
    run_program = 1'b1; step(); run_program = 1'b0;
  endtask

  task automatic do_us(input int s);
    wait_state(s, 2000);
    step(); ultrasound_done = 1'b1; step(); ultrasound_done = 1'b0;
  endtask

  task automatic to_pcalc(input logic [11:0] pc);
    do_us(1);
    do_us(5);
    wait_state(7, 50);
    step(); orient_result = 5'd7; orient_done = 1'b1; step(); orient_done = 1'b0; orient_result = 5'd0;
    wait_state(8, 10);
    step(); orient_result = 5'd12; orient_done = 1'b1; step(); orient_done = 1'b0; orient_result = 5'd0;
    wait_state(9, 10);
    step(); path_command = pc; path_done = 1'b1; step(); path_done = 1'b0;
  endtask

  task automatic finish_pass(input logic eq, input bit stray);
    wait_state(11, 100);
    if (stray) begin
      step(); run_program = 1'b1; step(); run_program = 1'b0;
    end
    do_us(12);
    wait_state(14, 20);
    step(); equal_result = eq; equal_done = 1'b1; step(); equal_done = 1'b0; equal_result = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run_program = 1'b0; abort = 1'b0;
    ultrasound_done = 1'b0; orient_done = 1'b0; orient_result = 5'd0;
    path_done = 1'b0; path_command = 12'h000; equal_done = 1'b0; equal_result = 1'b0;
    rover_location = 12'h345; target_location = 12'h3A0;
    repeat (3) step();
    cmp("rst_state", state, 0);          cmp("rst_busy", busy, 0);
    cmp("rst_error", error, 0);          cmp("rst_error_code", error_code, 0);
    cmp("rst_transmit_ir", transmit_ir, 0); cmp("rst_iteration", iteration, 0);
    cmp("rst_move_command", move_command, 0); cmp("rst_run_ultrasound", run_ultrasound, 0);
    reset = 1'b0;
    step();

    // Single pass, 6-unit move, stray run_program in MOVE2 ignored.
    sb.push_back(mk(0,1,0,0,1,'h203,0,0,7,12,'h345,'h3A0,2,6,30,2,3,1,0));
    start_run(); to_pcalc(12'h203); finish_pass(1'b1, 1'b1);
    wait_state(0, 20); step();

    // Single pass with maximal command: 255 + 15 + 1 = 271 units.
    sb.push_back(mk(0,1,0,0,1,'hFFF,0,0,7,12,'h345,'h3A0,2,6,1355,2,3,1,0));
    start_run(); to_pcalc(12'hFFF); finish_pass(1'b1, 1'b0);
    wait_state(0, 20); step();

    // Two failed checks hit the retry limit; last move is 1 unit.
    sb.push_back(mk(15,0,1,2,2,'h000,0,0,7,12,'h345,'h3A0,4,12,5,2,6,2,0));
    start_run(); to_pcalc(12'h100); finish_pass(1'b0, 1'b0);
    to_pcalc(12'h000); finish_pass(1'b0, 1'b0);
    wait_state(15, 20); step();

    // Ultrasound timeout in US2; restart from ERROR clears latched state.
    sb.push_back(mk(15,0,1,1,0,'h00A,0,0,0,0,'h345,0,1,3,0,20,2,0,0));
    start_run(); do_us(1); wait_state(5, 300); wait_state(15, 40); step();

    // Abort mid-IRTX2 together with a stray path_done.
    sb.push_back(mk(15,0,1,3,0,'h203,0,0,7,12,'h345,'h3A0,2,5,0,2,2,1,15));
    start_run(); to_pcalc(12'h203); wait_state(10, 10);
    step(); abort = 1'b1; path_done = 1'b1; step(); abort = 1'b0; path_done = 1'b0;
    cmp("abort_next_state", state, 15);
    cmp("abort_next_code", error_code, 3);
    cmp("abort_next_path_enable", path_enable, 0);
    step();

    // Reset in the middle of MOVE1 returns everything to zero.
    sb.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,1,3,0,0,1,0,0));
    start_run(); do_us(1); wait_state(4, 50);
    repeat (3) step();
    reset = 1'b1; step(); reset = 1'b0;
    step();

    // Normal restart after reset.
    sb.push_back(mk(0,1,0,0,1,'h203,0,0,7,12,'h345,'h3A0,2,6,30,2,3,1,0));
    start_run(); to_pcalc(12'h203); finish_pass(1'b1, 1'b0);
    wait_state(0, 20);
    repeat (5) step();

    cmp("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
